// File: rtl/mips_defs_pkg.sv
// Shared MIPS execute-stage definitions used by the divider.
package mips_defs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [4:0]  ALU_DIV      = 5'd26;
  localparam logic [4:0]  ALU_DIVU     = 5'd27;
  localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] part_s;
  logic [WIDTH:0] diff_s;

  assign part_s = {rem_i, quo_i[WIDTH-1]};
  assign diff_s = part_s - {1'b0, div_i};

  // part < 2*div, so the top bit of the difference is exactly the borrow
  always_comb begin
    if (diff_s[WIDTH] == 1'b0) begin
      rem_o = diff_s[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = part_s[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: stalls the pipeline until {HI, LO} is ready.
module div_unit
  import mips_defs_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 annul_i,
  output logic                 stall_o,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  div_state_t state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, div_q, div_d;
  logic               neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic               ready_q, ready_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0] a_mag_s, b_mag_s, step_rem_s, step_quo_s, rem_fix_s, quo_fix_s;

  assign a_mag_s = (signed_i & a_i[WIDTH-1]) ? ({WIDTH{1'b0}} - a_i) : a_i;
  assign b_mag_s = (signed_i & b_i[WIDTH-1]) ? ({WIDTH{1'b0}} - b_i) : b_i;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (div_q),
    .rem_o (step_rem_s),
    .quo_o (step_quo_s)
  );

  assign quo_fix_s = neg_quo_q ? ({WIDTH{1'b0}} - step_quo_s) : step_quo_s;
  assign rem_fix_s = neg_rem_q ? ({WIDTH{1'b0}} - step_rem_s) : step_rem_s;

  // Next-state, datapath load/iterate and result capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (annul_i) begin
          state_d = IDLE;
        end else if (start_i) begin
          neg_quo_d = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          neg_rem_d = signed_i & a_i[WIDTH-1];
          if (b_i == {WIDTH{1'b0}}) begin
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = {a_i, WIDTH'(DIV_ZERO_QUO)};
          end else begin
            state_d = BUSY;
            cnt_d   = {CW{1'b0}};
            rem_d   = {WIDTH{1'b0}};
            quo_d   = a_mag_s;
            div_d   = b_mag_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem_s;
          quo_d = step_quo_s;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = {rem_fix_s, quo_fix_s};
          end else begin
            state_d = BUSY;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      rem_q     <= {WIDTH{1'b0}};
      quo_q     <= {WIDTH{1'b0}};
      div_q     <= {WIDTH{1'b0}};
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= {(2*WIDTH){1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  assign ready_o  = ready_q;
  assign result_o = result_q;
  assign stall_o  = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_div_unit.sv
// Randomised and directed checks of div_unit against a plain-arithmetic model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        annul_i;
  logic        stall_o;
  logic        ready_o;
  logic [63:0] result_o;

  int n_total = 0;
  int n_bad   = 0;
  logic [63:0] last_exp;

  div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .signed_i (signed_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .annul_i  (annul_i),
    .stall_o  (stall_o),
    .ready_o  (ready_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: {remainder, quotient} from ordinary 64-bit integer arithmetic
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Called #1 after a rising edge; that cycle is cycle 0 of the instruction
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
    logic [63:0] exp;
    int lat, cyc, stalls;
    bit got;
    exp = ref_div(a, b, s);
    lat = (b == 32'd0) ? 1 : 33;
    start_i = 1'b1; signed_i = s; a_i = a; b_i = b;
    cyc = 0; stalls = 0; got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      if (stall_o) stalls++;
      if (ready_o) got = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
        a_i = $urandom; b_i = $urandom;
      end
    end
    check_val({tag, "_lat"}, 64'(cyc), 64'(lat));
    check_val({tag, "_res"}, result_o, exp);
    check_val({tag, "_stall"}, 64'(stalls), 64'(lat));
    last_exp = exp;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; a_i = 32'd0; b_i = 32'd0; annul_i = 1'b0;
    last_exp = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_val("rst_ready", 64'(ready_o), 64'd0);
    check_val("rst_result", result_o, 64'd0);
    check_val("rst_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_div(32'd100, 32'd7, 1'b0, "divu_100_7");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, "div_7_m2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf");
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, "divu_max_1");
    run_div(32'd5, 32'd0, 1'b0, "divu_zero");
    @(negedge clk);
    check_val("idle_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;

    // Annul in cycle 10, idle cycle 11, fresh start in cycle 12
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd1000; b_i = 32'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("annul_pre_ready", 64'(ready_o), 64'd0);
      @(posedge clk); #1;
    end
    annul_i = 1'b1;
    @(negedge clk);
    check_val("annul_stall", 64'(stall_o), 64'd0);
    check_val("annul_ready", 64'(ready_o), 64'd0);
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check_val("annul_post_ready", 64'(ready_o), 64'd0);
    check_val("annul_keep", result_o, last_exp);
    @(posedge clk); #1;
    run_div(32'd12345, 32'd67, 1'b0, "after_annul");

    // Back-to-back: second start in the cycle right after DONE
    run_div(32'hFFFF_FF00, 32'd10, 1'b1, "b2b_first");
    run_div(32'd999, 32'hFFFF_FFF0, 1'b1, "b2b_second");

    // Reset in the middle of a division
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd77; b_i = 32'd5;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("mid_rst_ready", 64'(ready_o), 64'd0);
    check_val("mid_rst_result", result_o, 64'd0);
    check_val("mid_rst_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_div(32'd77, 32'd5, 1'b0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
        default: rb = $urandom;
      endcase
      run_div(ra, rb, 1'($urandom_range(0, 1)), "rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the execute stage of the 5-stage MIPS pipeline, serving DIV and DIVU. It is started from the decoded execute-stage ALU control and holds the pipeline through the hazard unit via `stall_o` until the quotient and remainder are ready. It then delivers `{HI, LO}` to the HI/LO write path (hilowrite) in the same cycle the instruction is released.

## Interface
- `WIDTH`, default 32: operand width; the iteration counter is `$clog2(WIDTH)+1` bits.
- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_i` in 1: execute-stage instruction is DIV/DIVU; held high by the stalled pipeline.
- `signed_i` in 1: 1 = DIV (signed), 0 = DIVU; sampled with `start_i`.
- `a_i` in WIDTH: dividend (rs), sampled on the accepting edge.
- `b_i` in WIDTH: divisor (rt), sampled on the accepting edge.
- `annul_i` in 1: flushE / exception flush; abort any division in progress.
- `stall_o` out 1: combinational; request to stall F/D/E.
- `ready_o` out 1: registered; `result_o` valid this cycle.
- `result_o` out 2*WIDTH: `[63:32]` = remainder (HI), `[31:0]` = quotient (LO).

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE:**
  - If `start_i & ~annul_i`, latch |a|, |b| (magnitudes only when `signed_i`), the quotient sign (`a[31]^b[31]`) and the remainder sign (`a[31]`).
  - If `b_i == 0`, go to DONE with quotient = 0xFFFFFFFF and remainder = `a_i` (team-defined value; the architectural result is UNPREDICTABLE).
  - Otherwise go to BUSY with count = 0.
- **BUSY:**
  - One restoring-division step per cycle: shift {rem, quo} left, trial-subtract the divisor, set the quotient LSB when the difference is non-negative.
  - After count reaches WIDTH−1 (WIDTH steps), apply sign fix-up and go to DONE.
- **DONE:**
  - `ready_o` = 1 for exactly one cycle; next state is IDLE unconditionally.
  - A `start_i` still high in DONE does not restart; it is the same instruction leaving.
- Signed fix-up:
  - Negate the quotient if the signs differ.
  - Negate the remainder if the dividend is negative.
  - 0x80000000 / −1 gives quotient 0x80000000 and remainder 0 (wraps, no trap).
- `stall_o = start_i & ~ready_o & ~annul_i`.
- `annul_i` in any state: next state IDLE, `ready_o` stays 0, and `result_o` keeps its previous value.
- `start_i` in BUSY is ignored; operands are never re-sampled mid-division.
- `result_o` holds its last value until overwritten at the next DONE.

## Timing
- Reset: state IDLE, `ready_o` = 0, `result_o` = 0, counter = 0, `stall_o` = 0 (given `start_i` = 0).
- Normal latency, with `start_i` first high in cycle 0:
  - Cycles 1..32 are BUSY.
  - Cycle 33 is DONE with `ready_o` = 1.
  - `stall_o` is high in cycles 0..32 and low in cycle 33, so the instruction advances at the end of cycle 33 with HI/LO written.
- Divide-by-zero latency: `start_i` in cycle 0, DONE in cycle 1; `stall_o` is high in cycle 0 only.
- Back-to-back divides: the second `start_i` is accepted in the IDLE cycle after DONE, so there is a 1-cycle gap between instructions.
- `rst` mid-BUSY: IDLE on the next edge and the in-flight result is discarded.
- `rst` has priority over `annul_i`, and `annul_i` has priority over `start_i`.

## Structure
- Shared package `mips_defs_pkg`:
  - state enum `div_state_t` {IDLE, BUSY, DONE};
  - 5-bit ALU control constants `ALU_DIV`, `ALU_DIVU` (decode of `start_i` and `signed_i` happens outside the block);
  - `DIV_ZERO_QUO` = 32'hFFFFFFFF.
- One sub-module, `div_step`: combinational single restoring iteration with inputs {rem, quo, divisor} and outputs {rem', quo'}. The FSM, counter and sign fix-up stay in `div_unit`.

## Test plan
- DIVU 100 / 7, start held → `stall_o` high 33 cycles; `ready_o` in cycle 33 with `result_o` = {32'd2, 32'd14}.
- DIV −7 / 2 (0xFFFFFFF9 / 2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIV 7 / −2 → quotient 0xFFFFFFFD, remainder 1.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, no hang; DIVU 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- DIVU 5 / 0 → `ready_o` in cycle 1 with `result_o` = {32'd5, 32'hFFFFFFFF}; `stall_o` high in cycle 0 only.
- `annul_i` pulsed in cycle 10 of BUSY → IDLE in cycle 11, no `ready_o`, `result_o` unchanged; a fresh start in cycle 12 completes correctly in cycle 45.
- Two consecutive DIVs (start re-asserted in the cycle after DONE) → both results correct; `rst` asserted mid-BUSY → all outputs at reset values the following cycle.
